// File: rtl/conv2_pkg.sv
// Shared conv2 types and constants, used by both the processing element and the
// accumulator stage.
package conv2_pkg;

    typedef logic signed [31:0] conv2_prod_t;
    typedef logic signed [15:0] conv2_act_t;

    localparam int ACT_MAX = 32767;
    localparam int ACT_MIN = -32768;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        ROUND,
        OUT
    } conv2_state_t;

endpackage

// File: rtl/conv2_requant.sv
// Combinational requantiser: round-half-up shift, 16-bit saturation and optional
// ReLU (enabled by defining CONV2_ACC_RELU_EN).
module conv2_requant
    import conv2_pkg::*;
#(
    parameter int ACC_W = 44,
    parameter int SHIFT = 8
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [ACC_W:0]   rounded,
    input  logic signed [ACC_W:0]   r,
    output conv2_act_t              act
);

    // One guard bit keeps acc + half from wrapping when acc sits near full scale.
    localparam logic [ACC_W:0] HALF = ((ACC_W + 1)'(1) << SHIFT) >> 1;
    localparam logic signed [ACC_W:0] HI = (ACC_W + 1)'(ACT_MAX);
    localparam logic signed [ACC_W:0] LO = (ACC_W + 1)'(ACT_MIN);

    logic signed [ACC_W:0] biased;

    function automatic conv2_act_t sat16(input logic signed [ACC_W:0] v);
        if (v > HI) begin
            return conv2_act_t'(ACT_MAX);
        end
        if (v < LO) begin
            return conv2_act_t'(ACT_MIN);
        end
        return conv2_act_t'(v[15:0]);
    endfunction

    assign biased  = $signed({acc[ACC_W-1], acc}) + $signed(HALF);
    assign rounded = biased >>> SHIFT;

`ifdef CONV2_ACC_RELU_EN
    function automatic conv2_act_t relu(input conv2_act_t v);
        return (v < 0) ? '0 : v;
    endfunction

    assign act = relu(sat16(r));
`else
    assign act = sat16(r);
`endif

endmodule

// File: rtl/conv2_accumulator.sv
// conv2 accumulator: sums NUM_TERMS PE products onto a bias, then requantises to a
// 16-bit activation. Define CONV2_ACC_RELU_EN to clamp negative results to zero.
module conv2_accumulator
    import conv2_pkg::*;
#(
    parameter int NUM_TERMS = 8,
    parameter int ACC_W     = 44,
    parameter int SHIFT     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  conv2_prod_t bias,
    input  logic        in_valid,
    input  conv2_prod_t in_data,
    output logic        in_ready,
    output conv2_act_t  odata,
    output logic        done
);

    localparam int CNT_W = $clog2(NUM_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);

    if (NUM_TERMS < 1 || NUM_TERMS > 1024) begin : g_bad_terms
        $error("conv2_accumulator: NUM_TERMS must be in 1..1024");
    end
    if (ACC_W < 33 + $clog2(NUM_TERMS)) begin : g_bad_acc_w
        $error("conv2_accumulator: ACC_W too narrow for NUM_TERMS");
    end
    if (SHIFT < 0 || SHIFT > 31) begin : g_bad_shift
        $error("conv2_accumulator: SHIFT must be in 0..31");
    end

    conv2_state_t            state;
    conv2_state_t            state_next;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        cnt;
    logic signed [ACC_W:0]   r;
    logic signed [ACC_W:0]   rounded;
    conv2_act_t              act;
    logic                    accept;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = (NUM_TERMS == 1) ? ROUND : ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && cnt == LAST_CNT) begin
                    state_next = ROUND;
                end
            end
            ROUND:   state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (clear) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            r     <= '0;
            odata <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                case (state)
                    IDLE: if (accept) begin
                        acc <= ACC_W'(bias) + ACC_W'(in_data);
                        cnt <= CNT_W'(1);
                    end
                    ACCUM: if (accept) begin
                        acc <= acc + ACC_W'(in_data);
                        cnt <= cnt + CNT_W'(1);
                    end
                    // ROUND -> OUT boundary: rounded/shifted sum registered in r
                    ROUND: r <= rounded;
                    OUT: begin
                        odata <= act;
                        done  <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    conv2_requant #(
        .ACC_W(ACC_W),
        .SHIFT(SHIFT)
    ) u_requant (
        .acc    (acc),
        .rounded(rounded),
        .r      (r),
        .act    (act)
    );

endmodule

// File: tb/tb_conv2_accumulator.sv
// Self-checking bench for conv2_accumulator with NUM_TERMS=4, SHIFT=8: table vectors,
// hand-written corner sequences and randomized transactions against a sum model.
module tb_conv2_accumulator;

    localparam int NT = 4;
    localparam int SH = 8;
    localparam int AW = 44;

`ifdef CONV2_ACC_RELU_EN
    localparam logic signed [15:0] NEG_SAT = 16'sd0;
    localparam logic signed [15:0] NEG5    = 16'sd0;
`else
    localparam logic signed [15:0] NEG_SAT = -16'sd32768;
    localparam logic signed [15:0] NEG5    = -16'sd5;
`endif

    typedef struct packed {
        logic signed [31:0] bias;
        logic [3:0][31:0]   t;
        logic [7:0]         gap;
        logic signed [15:0] expv;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               clear;
    logic signed [31:0] bias;
    logic               in_valid;
    logic signed [31:0] in_data;
    logic               in_ready;
    logic signed [15:0] odata;
    logic               done;

    int total = 0;
    int bad = 0;
    int done_seen = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_seen++;

    conv2_accumulator #(
        .NUM_TERMS(NT),
        .ACC_W    (AW),
        .SHIFT    (SH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .bias    (bias),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready),
        .odata   (odata),
        .done    (done)
    );

    task automatic check(input string name, input longint got, input longint expv);
        total++;
        if (got != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    // Reference: exact integer sum, floor((sum + half) / 2^SH), clamp, optional ReLU.
    function automatic longint model(input logic signed [31:0] b, input logic [3:0][31:0] t);
        longint s;
        s = longint'(b);
        for (int i = 0; i < NT; i++) s += longint'($signed(t[i]));
        s = (s + (longint'(1) << (SH - 1))) >>> SH;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`ifdef CONV2_ACC_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    function automatic vec_t mk(input logic signed [31:0] b, input logic [31:0] t0,
                                input logic [31:0] t1, input logic [31:0] t2,
                                input logic [31:0] t3, input int gap,
                                input logic signed [15:0] e);
        vec_t v;
        v.bias = b;
        v.t[0] = t0;
        v.t[1] = t1;
        v.t[2] = t2;
        v.t[3] = t3;
        v.gap  = 8'(gap);
        v.expv = e;
        return v;
    endfunction

    function automatic logic [31:0] rnd_val();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 2))
            0:       return r;
            1:       return {{12{r[19]}}, r[19:0]};
            default: return {{18{r[13]}}, r[13:0]};
        endcase
    endfunction

    // Present one term and return just after the edge that accepted it.
    task automatic term_accept(input logic signed [31:0] b, input logic [31:0] d);
        int w;
        bias     = b;
        in_data  = d;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (w >= 20) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output logic signed [15:0] v, output int k, output int rdy);
        k = 0;
        rdy = 0;
        v = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            k++;
            if (done) begin
                v = odata;
                return;
            end
            if (in_ready) rdy++;
        end
        k = 99;
    endtask

    task automatic run_txn(input logic signed [31:0] b, input logic [3:0][31:0] t,
                           input int gap, output logic signed [15:0] v,
                           output int k, output int rdy);
        for (int i = 0; i < NT; i++) begin
            term_accept(b, t[i]);
            if (i < NT - 1 && gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        wait_done(v, k, rdy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t               tab[7];
        vec_t               rv;
        logic signed [15:0] v;
        int                 k;
        int                 rdy;
        int                 ds0;

        rst      = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b0;
        bias     = '0;
        in_data  = '0;
        #1;
        check("reset_odata", odata, 0);
        check("reset_done", done, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_in_ready", in_ready, 1);

        tab[0] = mk(256, 512, 768, 1024, -256, 0, 16'sd9);
        tab[1] = mk(0, 128, 0, 0, 0, 0, 16'sd1);
        tab[2] = mk(0, 127, 0, 0, 0, 0, 16'sd0);
        tab[3] = mk(0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, 16'sd32767);
        tab[4] = mk(0, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 0, NEG_SAT);
        tab[5] = mk(-1280, 0, 0, 0, 0, 0, NEG5);
        tab[6] = mk(256, 512, 768, 1024, -256, 3, 16'sd9);

        for (int i = 0; i < 7; i++) begin
            run_txn(tab[i].bias, tab[i].t, int'(tab[i].gap), v, k, rdy);
            check($sformatf("vec%0d_odata", i), v, tab[i].expv);
            check($sformatf("vec%0d_latency", i), k, 3);
            check($sformatf("vec%0d_ready_busy", i), rdy, 0);
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), done, 0);
            check($sformatf("vec%0d_odata_hold", i), odata, tab[i].expv);
        end

        // Term held valid through ROUND/OUT must wait for IDLE, then start the next sum.
        rv = mk(-1280, 300, -45, 7000, 12, 0, 16'sd0);
        for (int i = 0; i < NT; i++) term_accept(256, tab[0].t[i]);
        bias     = rv.bias;
        in_data  = rv.t[0];
        in_valid = 1'b1;
        wait_done(v, k, rdy);
        check("bp_first_odata", v, 9);
        check("bp_ready_busy", rdy, 0);
        check("bp_latency", k, 3);
        @(posedge clk);
        #1;
        for (int i = 1; i < NT; i++) term_accept(rv.bias, rv.t[i]);
        in_valid = 1'b0;
        wait_done(v, k, rdy);
        check("bp_second_odata", v, model(rv.bias, rv.t));
        @(negedge clk);

        // clear after two terms, with a competing term in the same cycle.
        ds0 = done_seen;
        term_accept(256, 512);
        term_accept(256, 768);
        in_data  = 1024;
        in_valid = 1'b1;
        clear    = 1'b1;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clear_in_ready", in_ready, 1);
        run_txn(256, tab[0].t, 0, v, k, rdy);
        check("clear_odata", v, 9);
        check("clear_latency", k, 3);
        @(negedge clk);
        #1;
        check("clear_single_done", done_seen - ds0, 1);

        // Asynchronous reset mid-accumulation.
        term_accept(256, 512);
        term_accept(256, 768);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_async_odata", odata, 0);
        check("rst_async_done", done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_rel_in_ready", in_ready, 1);
        check("rst_rel_odata", odata, 0);
        check("rst_rel_done", done, 0);
        run_txn(256, tab[0].t, 0, v, k, rdy);
        check("rst_after_odata", v, 9);
        check("rst_after_latency", k, 3);
        @(negedge clk);

        for (int n = 0; n < 30; n++) begin
            rv.bias = $signed(rnd_val());
            for (int i = 0; i < NT; i++) rv.t[i] = rnd_val();
            run_txn(rv.bias, rv.t, $urandom_range(0, 2), v, k, rdy);
            check($sformatf("rand%0d_odata", n), v, model(rv.bias, rv.t));
            check($sformatf("rand%0d_latency", n), k, 3);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
